// File: rtl/gauss_pkg.sv
// Shared types for the Gaussian filter pixel stream: frame defaults, the
// buffered beat layout and the stream source FSM states.
package gauss_pkg;

    localparam int GAUSS_PIX_W = 8;
    localparam int GAUSS_ROWS  = 168;
    localparam int GAUSS_COLS  = 220;

    typedef struct packed {
        logic [GAUSS_PIX_W-1:0] data;
        logic                   sof;
        logic                   eol;
        logic                   eof;
    } beat_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } stream_state_e;

endpackage

// File: rtl/gauss_beat_fifo2.sv
// Two-entry FIFO of stream beats; the producer guarantees it never pushes
// when full and the consumer never pops when empty.
module gauss_beat_fifo2
    import gauss_pkg::*;
#(
    parameter type T = beat_t
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  T           din_i,
    input  logic       pop_i,
    output T           dout_o,
    output logic       full_o,
    output logic       empty_o,
    output logic [1:0] count_o
);

    T           mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) wr_ptr_q <= ~wr_ptr_q;
            if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == 2'd0);
    assign full_o  = (count_q == 2'd2);
    assign count_o = count_q;

endmodule

// File: rtl/gauss_pixel_stream_tx.sv
// Raster pixel source: reads a frame from synchronous-read RAM and emits it as
// a valid/ready stream with sof/eol/eof flags.
module gauss_pixel_stream_tx
    import gauss_pkg::*;
#(
    parameter int ROWS   = GAUSS_ROWS,
    parameter int COLS   = GAUSS_COLS,
    parameter int PIX_W  = GAUSS_PIX_W,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [PIX_W-1:0]  m_data,
    output logic              m_sof,
    output logic              m_eol,
    output logic              m_eof
);

    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

    typedef struct packed {
        logic [PIX_W-1:0] data;
        logic             sof;
        logic             eol;
        logic             eof;
    } pix_beat_t;

    stream_state_e     state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic              infl_p1_q;
    logic              sof_p1_q, eol_p1_q, eof_p1_q;

    pix_beat_t         push_beat, head_beat;
    logic              fifo_full, fifo_empty;
    logic [1:0]        fifo_count;
    logic [1:0]        occ;
    logic              pop;
    logic              rd_sof, rd_eol, rd_eof;

    assign rd_sof = (row_q == '0) && (col_q == '0);
    assign rd_eol = (col_q == COL_LAST);
    assign rd_eof = (row_q == ROW_LAST) && rd_eol;
    assign pop    = m_valid & m_ready;
    // Credits cover both buffered beats and the read still in the RAM pipe.
    assign occ    = fifo_full ? 2'd2 : fifo_count + {1'b0, infl_p1_q};

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        addr_d    = addr_q;
        mem_rd_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ISSUE;
                    row_d   = '0;
                    col_d   = '0;
                    addr_d  = '0;
                end
            end
            ST_ISSUE: begin
                mem_rd_en = (occ - {1'b0, pop}) < 2'd2;
                if (mem_rd_en) begin
                    if (rd_eof) begin
                        state_d = ST_DRAIN;
                    end else begin
                        addr_d = addr_q + 1'b1;
                        if (rd_eol) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && head_beat.eof) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            row_q     <= '0;
            col_q     <= '0;
            addr_q    <= '0;
            infl_p1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            addr_q    <= addr_d;
            infl_p1_q <= mem_rd_en;
        end
    end

    // Stage p1: flags ride alongside the read until RAM data returns.
    always_ff @(posedge clk) begin
        if (mem_rd_en) begin
            sof_p1_q <= rd_sof;
            eol_p1_q <= rd_eol;
            eof_p1_q <= rd_eof;
        end
    end

    assign push_beat = '{data: mem_rd_data, sof: sof_p1_q, eol: eol_p1_q, eof: eof_p1_q};

    gauss_beat_fifo2 #(
        .T (pix_beat_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (infl_p1_q),
        .din_i   (push_beat),
        .pop_i   (pop),
        .dout_o  (head_beat),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign mem_addr = addr_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign m_valid  = ~fifo_empty;
    assign m_data   = m_valid ? head_beat.data : '0;
    assign m_sof    = m_valid & head_beat.sof;
    assign m_eol    = m_valid & head_beat.eol;
    assign m_eof    = m_valid & head_beat.eof;

endmodule

// File: tb/tb_gauss_pixel_stream_tx.sv
// Scoreboard bench for the raster pixel source: 3x4 frame under several
// ready patterns, restart/reset cases, and a 1x1 degenerate frame.
module tb_gauss_pixel_stream_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, busy, done, mem_rd_en;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rd_data;
    logic        m_valid, m_ready;
    logic [7:0]  m_data;
    logic        m_sof, m_eol, m_eof;

    logic        start1, busy1, done1, mem_rd_en1;
    logic [15:0] mem_addr1;
    logic [7:0]  mem_rd_data1;
    logic        m_valid1;
    logic        m_ready1 = 1'b1;
    logic [7:0]  m_data1;
    logic        m_sof1, m_eol1, m_eof1;

    gauss_pixel_stream_tx #(.ROWS(3), .COLS(4), .PIX_W(8), .ADDR_W(16)) u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof)
    );

    gauss_pixel_stream_tx #(.ROWS(1), .COLS(1), .PIX_W(8), .ADDR_W(16)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .mem_rd_en(mem_rd_en1), .mem_addr(mem_addr1), .mem_rd_data(mem_rd_data1),
        .m_valid(m_valid1), .m_ready(m_ready1), .m_data(m_data1),
        .m_sof(m_sof1), .m_eol(m_eol1), .m_eof(m_eof1)
    );

    // Frame RAMs: RAM[i] = i + 16 for the 3x4 frame, RAM[0] = 0xAB for 1x1.
    always @(posedge clk) begin
        if (mem_rd_en)  mem_rd_data  <= mem_addr[7:0] + 8'h10;
        if (mem_rd_en1) mem_rd_data1 <= (mem_addr1 == 16'd0) ? 8'hAB : 8'hEE;
    end

    typedef struct {
        logic [7:0] data;
        logic [2:0] flags;
        int         cyc;
    } exp_t;

    exp_t  sb[$];
    exp_t  e_mon;
    int    checks = 0;
    int    errors = 0;
    int    cyc_abs = 0;
    int    t0 = 0;
    int    issued = 0;
    int    popped = 0;
    int    beats = 0;
    int    dones = 0;
    int    exp_done_cyc = -1;
    int    rdy_mode = 0;
    int    ph = 0;
    bit    hold = 1'b0;
    logic [10:0] held;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc_abs++;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1:       m_ready = (ph == 0) || (ph == 3);
            2:       m_ready = 1'b0;
            default: m_ready = 1'b1;
        endcase
        ph = (ph + 1) % 4;
    end

    // Monitor for the 3x4 instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            issued = 0;
            popped = 0;
            hold   = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_valid", {31'd0, m_valid}, 32'd1);
                chk("hold_beat", {21'd0, m_data, m_sof, m_eol, m_eof}, {21'd0, held});
            end
            if (mem_rd_en) begin
                chk("credit", {31'd0, (issued - popped - int'(m_valid && m_ready)) < 2}, 32'd1);
                chk("rd_addr", {16'd0, mem_addr}, issued);
                issued++;
            end
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    chk("extra_beat", 32'd1, 32'd0);
                end else begin
                    e_mon = sb.pop_front();
                    chk("beat_data", {24'd0, m_data}, {24'd0, e_mon.data});
                    chk("beat_flags", {29'd0, m_sof, m_eol, m_eof}, {29'd0, e_mon.flags});
                    if (e_mon.cyc >= 0) chk("beat_cyc", cyc_abs - t0, e_mon.cyc);
                end
                popped++;
                beats++;
            end
            if (done) begin
                dones++;
                if (exp_done_cyc >= 0) chk("done_cyc", cyc_abs - t0, exp_done_cyc);
            end
            hold = m_valid && !m_ready;
            held = {m_data, m_sof, m_eol, m_eof};
            if (start && !busy) begin
                issued = 0;
                popped = 0;
            end
        end
    end

    task automatic load_frame(input bit timed);
        for (int k = 0; k < 12; k++) begin
            exp_t e;
            e.data  = 8'(16 + k);
            e.flags = {k == 0, (k % 4) == 3, k == 11};
            e.cyc   = timed ? 3 + k : -1;
            sb.push_back(e);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        t0    = cyc_abs;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input bit start_on_done);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(posedge clk); #1;
            if (done) begin
                seen = 1'b1;
                if (start_on_done) start = 1'b1;
            end
        end
        chk("done_seen", {31'd0, seen}, 32'd1);
        if (start_on_done) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    task automatic frame_end(input string tag, input int b0, input int d0);
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_beats"}, beats - b0, 32'd12);
        chk({tag, "_dones"}, dones - d0, 32'd1);
        chk({tag, "_sb_empty"}, sb.size(), 32'd0);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, d0;
        rst = 1'b1; start = 1'b0; start1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_done",  {31'd0, done}, 32'd0);
        chk("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
        chk("rst_addr",  {16'd0, mem_addr}, 32'd0);
        chk("rst_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_data",  {24'd0, m_data}, 32'd0);
        chk("rst_flags", {29'd0, m_sof, m_eol, m_eof}, 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Full-rate frame with exact timing.
        b0 = beats; d0 = dones;
        load_frame(1'b1);
        exp_done_cyc = 15;
        pulse_start();
        wait_done(40, 1'b0);
        frame_end("t1", b0, d0);
        exp_done_cyc = -1;

        // Toggling ready; start during the done cycle must be ignored.
        rdy_mode = 1;
        @(posedge clk);
        b0 = beats; d0 = dones;
        load_frame(1'b0);
        pulse_start();
        wait_done(100, 1'b1);
        rdy_mode = 0;
        frame_end("t2", b0, d0);

        // Ready held low: two reads then stall with pixel 0 presented.
        rdy_mode = 2;
        repeat (2) @(posedge clk);
        b0 = beats; d0 = dones;
        load_frame(1'b0);
        pulse_start();
        repeat (10) @(posedge clk);
        #1;
        chk("t3_reads", issued, 32'd2);
        chk("t3_valid", {31'd0, m_valid}, 32'd1);
        chk("t3_data",  {24'd0, m_data}, 32'h10);
        chk("t3_sof",   {31'd0, m_sof}, 32'd1);
        rdy_mode = 0;
        wait_done(60, 1'b0);
        frame_end("t3", b0, d0);

        // Second start mid-frame is ignored.
        b0 = beats; d0 = dones;
        load_frame(1'b0);
        pulse_start();
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(60, 1'b0);
        repeat (20) @(posedge clk);
        frame_end("t4", b0, d0);

        // Reset in cycle 8 aborts the frame; a new start begins at pixel 0.
        load_frame(1'b0);
        pulse_start();
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t5_busy",  {31'd0, busy}, 32'd0);
        chk("t5_valid", {31'd0, m_valid}, 32'd0);
        chk("t5_rd_en", {31'd0, mem_rd_en}, 32'd0);
        chk("t5_done",  {31'd0, done}, 32'd0);
        d0 = dones;
        repeat (10) @(posedge clk);
        #1;
        chk("t5_no_done", dones - d0, 32'd0);
        sb.delete();
        b0 = beats; d0 = dones;
        load_frame(1'b1);
        exp_done_cyc = 15;
        pulse_start();
        wait_done(40, 1'b0);
        frame_end("t5", b0, d0);
        exp_done_cyc = -1;

        // 1x1 degenerate frame.
        @(posedge clk); #1;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        chk("u1_rd_en", {31'd0, mem_rd_en1}, 32'd1);
        chk("u1_addr",  {16'd0, mem_addr1}, 32'd0);
        @(posedge clk); #1;
        chk("u1_no_rd", {31'd0, mem_rd_en1}, 32'd0);
        @(posedge clk); #1;
        chk("u1_valid", {31'd0, m_valid1}, 32'd1);
        chk("u1_data",  {24'd0, m_data1}, 32'hAB);
        chk("u1_flags", {29'd0, m_sof1, m_eol1, m_eof1}, 32'd7);
        chk("u1_done_early", {31'd0, done1}, 32'd0);
        @(posedge clk); #1;
        chk("u1_done",  {31'd0, done1}, 32'd1);
        chk("u1_drained", {31'd0, m_valid1}, 32'd0);
        @(posedge clk); #1;
        chk("u1_done_pulse", {31'd0, done1}, 32'd0);
        chk("u1_idle",  {31'd0, busy1}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gauss_pixel_stream_tx.md
Name: gauss_pixel_stream_tx

Overview:
- Synthesizable raster pixel source for the Gaussian filter datapath.
- Reads a grayscale frame (ROWS x COLS, one byte per pixel, row-major, the same layout the hex frame loader produces) from a synchronous-read frame RAM.
- Emits the frame as a valid/ready pixel stream with sof/eol/eof side flags.
- Is the transmitting end of the pixel stream that the streaming convolution stage and the output writer consume.

Parameters:
- ROWS, 168, frame height in pixels.
- COLS, 220, frame width in pixels.
- PIX_W, 8, pixel width in bits.
- ADDR_W, 16, frame RAM address width; must satisfy 2^ADDR_W >= ROWS*COLS.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to stream one frame; ignored while busy.
- busy  out  1  high from the cycle after start is accepted through the done cycle.
- done  out  1  one-cycle pulse after the eof pixel handshake.
- mem_rd_en  out  1  frame RAM read strobe.
- mem_addr  out  ADDR_W  frame RAM address; pixel index = row*COLS + col.
- mem_rd_data  in  PIX_W  RAM data, valid exactly one cycle after mem_rd_en.
- m_valid  out  1  stream data valid.
- m_ready  in  1  downstream ready.
- m_data  out  PIX_W  pixel value.
- m_sof  out  1  first pixel of frame (index 0).
- m_eol  out  1  last pixel of a row (col == COLS-1).
- m_eof  out  1  last pixel of frame (index ROWS*COLS-1).

Behaviour:
- Reset values: busy=0, done=0, mem_rd_en=0, mem_addr=0, m_valid=0, m_data=0, all flags 0; state IDLE; counters and buffer cleared.
- States:
  - IDLE: waits for start. start moves the block to ISSUE and resets row, col and address to 0.
  - ISSUE: issues reads in raster order. After the read of index ROWS*COLS-1 the block moves to DRAIN.
  - DRAIN: no further reads. Moves to DONE when the eof beat is accepted (m_valid & m_ready & m_eof).
  - DONE: held for one cycle with done=1, then IDLE.
- Output buffer: 2-entry FIFO holding {data, sof, eol, eof}.
  - Flags are computed from the issue-side row/col counters.
  - Flags are pipelined alongside the in-flight read.
- Credit rule: occ = buffered entries + in-flight reads (0..2).
  - In ISSUE, mem_rd_en=1 iff (occ - pop_this_cycle) < 2, where pop = m_valid & m_ready.
  - The FIFO never overflows.
  - Sustains 1 pixel/cycle while m_ready is held high.
- Latency:
  - start high in cycle 0.
  - First mem_rd_en with addr 0 in cycle 1.
  - RAM data arrives in cycle 2 and is written into the FIFO.
  - m_valid=1 with pixel 0 in cycle 3.
- Stream rules:
  - Once m_valid=1, m_data and the flags hold stable until accepted.
  - m_valid is never deasserted without a handshake.
  - m_valid may be high in the same cycle that the last read is issued.
- Counters:
  - col wraps COLS-1 -> 0 and increments row.
  - mem_addr increments by 1 per issued read; it does not wrap within a frame.
  - No read is issued beyond index ROWS*COLS-1.
- Boundary cases:
  - Degenerate 1-column frame: every pixel has eol=1.
  - Degenerate 1x1 frame: one beat with sof=eol=eof=1.
  - start while busy is ignored; no second frame is queued.
  - start in the same cycle as the done pulse is ignored.
  - m_ready low indefinitely: reads stop once occ=2; the data is held.
  - rst asserted mid-frame: every output returns to its reset value on the next edge; any in-flight read data is discarded; no done pulse.

Decomposition:
- Shared package gauss_pkg:
  - PIX_W default.
  - Default ROWS/COLS.
  - Beat struct {data, sof, eol, eof}.
  - Stream FSM state enum (IDLE/ISSUE/DRAIN/DONE).
- One sub-module: gauss_beat_fifo2.
  - 2-entry FIFO of beat structs.
  - Ports: push, pop, full, empty and occupancy count.
- The top module holds the FSM, counters and credit logic.

Test Plan:
- ROWS=3, COLS=4, RAM[i]=i+16, m_ready=1 -> 12 beats on consecutive cycles 3..14, data 0x10..0x1B, sof only on beat 0, eol on beats 3/7/11, eof on beat 11, done pulse in cycle 15.
- Same frame with m_ready toggling 1,0,0,1 repeating -> identical beat sequence with no loss or duplication, and held data stable while m_ready=0. Check mem_rd_en never fires with occ=2 and no pop.
- m_ready=0 from cycle 0 -> exactly 2 reads issued (addr 0,1), then none. m_valid=1 with data 0x10 held. Releasing m_ready resumes from addr 2.
- start pulsed again in cycle 6 during the frame -> ignored; exactly 12 beats and a single done.
- rst asserted in cycle 8 mid-frame -> next cycle busy=0, m_valid=0, mem_rd_en=0, no done. A new start then streams from pixel 0 with sof=1.
- ROWS=1, COLS=1, RAM[0]=0xAB -> single beat 0xAB with sof=eol=eof=1, done one cycle after the handshake.
